// File: rtl/seq_pkg.sv
// Shared sizing constants and FSM state encoding for the step pattern sequencer.
package seq_pkg;

    localparam int unsigned NUM_STEPS = 16;
    localparam int unsigned NUM_TONES = 12;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
    localparam logic [1:0] ST_PLAY  = 2'd2;
    localparam logic [1:0] ST_CLEAR = 2'd3;

    // ARM gives up after this many extra low cycles of play_en (four in total).
    localparam logic [1:0] ARM_TIMEOUT = 2'd3;

endpackage

// File: rtl/step_counter.sv
// Current-step counter with seq_len clamping and a registered one-cycle wrap pulse.
module step_counter #(
    parameter int unsigned NUM_STEPS = seq_pkg::NUM_STEPS,
    localparam int unsigned STEP_W   = $clog2(NUM_STEPS)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_step,
    input  logic              i_restart,
    input  logic [STEP_W:0]   i_seq_len,
    output logic [STEP_W-1:0] o_cur_step,
    output logic              o_wrap
);

    logic [STEP_W:0]   w_len;
    logic              w_at_end;
    logic [STEP_W-1:0] r_cur;
    logic              r_wrap;

    assign w_len = (i_seq_len == '0 || 32'(i_seq_len) > NUM_STEPS) ?
                   (STEP_W+1)'(NUM_STEPS) : i_seq_len;

    // >= so a step left beyond a freshly shrunk length still wraps on the next pulse
    assign w_at_end = ({1'b0, r_cur} >= (w_len - (STEP_W+1)'(1)));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cur  <= '0;
            r_wrap <= 1'b0;
        end else if (i_restart) begin
            r_cur  <= '0;
            r_wrap <= 1'b0;
        end else if (i_step) begin
            if (w_at_end) begin
                r_cur  <= '0;
                r_wrap <= 1'b1;
            end else begin
                r_cur  <= r_cur + STEP_W'(1);
                r_wrap <= 1'b0;
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign o_cur_step = r_cur;
    assign o_wrap     = r_wrap;

endmodule

// File: rtl/step_pattern_sequencer.sv
// Step sequencer: editable tone pattern memory, IDLE/ARM/PLAY/CLEAR control FSM and
// registered tone-mask output for the audio interface.
module step_pattern_sequencer #(
    parameter int unsigned NUM_STEPS = seq_pkg::NUM_STEPS,
    parameter int unsigned NUM_TONES = seq_pkg::NUM_TONES,
    localparam int unsigned STEP_W   = $clog2(NUM_STEPS)
) (
    input  logic                 CLOCK_50,
    input  logic                 nReset,
    input  logic                 nStart,
    input  logic                 nClear,
    input  logic                 bpm_step,
    input  logic                 play_en,
    input  logic                 edit_toggle,
    input  logic [STEP_W-1:0]    edit_step,
    input  logic [3:0]           edit_tone,
    input  logic [STEP_W:0]      seq_len,
    output logic [NUM_TONES-1:0] Select,
    output logic [STEP_W-1:0]    cur_step,
    output logic                 wrap,
    output logic                 busy
);

    import seq_pkg::*;

    logic [1:0]           r_state;
    logic [1:0]           w_state_d;
    logic [1:0]           r_arm_cnt;
    logic [STEP_W-1:0]    r_clr_idx;
    logic [NUM_TONES-1:0] r_pattern [NUM_STEPS];
    logic [NUM_TONES-1:0] r_select;
    logic [NUM_TONES-1:0] w_edit_mask;
    logic                 w_clr_last;
    logic                 w_edit_en;
    logic                 w_step;
    logic                 w_restart;

    assign w_clr_last  = (r_clr_idx == STEP_W'(NUM_STEPS - 1));
    assign w_edit_en   = edit_toggle && (r_state != ST_CLEAR) && (32'(edit_tone) < NUM_TONES);
    assign w_edit_mask = NUM_TONES'(1) << edit_tone;
    assign w_step      = bpm_step && (r_state == ST_PLAY);
    assign w_restart   = !nStart && ((r_state == ST_IDLE) || (r_state == ST_PLAY));

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!nClear)      w_state_d = ST_CLEAR;
                else if (!nStart) w_state_d = ST_ARM;
            end
            ST_ARM: begin
                if (!nClear)                        w_state_d = ST_CLEAR;
                else if (play_en)                   w_state_d = ST_PLAY;
                else if (r_arm_cnt == ARM_TIMEOUT)  w_state_d = ST_IDLE;
            end
            ST_PLAY: begin
                if (!nClear)       w_state_d = ST_CLEAR;
                else if (!play_en) w_state_d = ST_IDLE;
            end
            ST_CLEAR: begin
                if (w_clr_last) w_state_d = ST_IDLE;
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            r_state   <= ST_IDLE;
            r_arm_cnt <= '0;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_d;
            r_arm_cnt <= (r_state == ST_ARM && !play_en) ? r_arm_cnt + 2'd1 : 2'd0;
            r_clr_idx <= (r_state == ST_CLEAR) ? r_clr_idx + STEP_W'(1) : '0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            for (int unsigned i = 0; i < NUM_STEPS; i++) r_pattern[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_STEPS; i++) begin
                if (r_state == ST_CLEAR && r_clr_idx == STEP_W'(i)) begin
                    r_pattern[i] <= '0;
                end else if (w_edit_en && edit_step == STEP_W'(i)) begin
                    r_pattern[i] <= r_pattern[i] ^ w_edit_mask;
                end
            end
        end
    end

    // Gated on next state so Select drops on the same edge that leaves PLAY.
    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) r_select <= '0;
        else         r_select <= (w_state_d == ST_PLAY) ? r_pattern[cur_step] : '0;
    end

    step_counter #(
        .NUM_STEPS (NUM_STEPS)
    ) u_step_counter (
        .i_clk      (CLOCK_50),
        .i_rst_n    (nReset),
        .i_step     (w_step),
        .i_restart  (w_restart),
        .i_seq_len  (seq_len),
        .o_cur_step (cur_step),
        .o_wrap     (wrap)
    );

    assign Select = r_select;
    assign busy   = (r_state == ST_CLEAR);

endmodule
